// File: rtl/tohost_reporter_if.sv
// rtl/tohost_reporter_if.sv - byte stream from the tohost reporter to the UART TX FIFO
interface tohost_reporter_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/tohost_reporter.sv
// rtl/tohost_reporter.sv - streams each tohost CSR write as ASCII hex and decodes done/pass flags
module tohost_reporter #(
  parameter bit SEND_NL = 1'b1,
  parameter bit UPPER   = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               csr_we,
  input  logic [31:0]        csr_wdata,
  tohost_reporter_if.master  tx,
  output logic               busy,
  output logic [7:0]         drop_cnt,
  output logic               test_done,
  output logic               test_pass
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HEX  = 2'd1;
  localparam logic [1:0] NL   = 2'd2;

  logic [1:0]  state;
  logic [31:0] shreg;
  logic [2:0]  idx;
  logic [31:0] pending;
  logic        pending_v;
  logic        accept;
  logic        last_hex;
  logic        eof;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10)
      return 8'h30 + {4'h0, n};
    else
      return (UPPER ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
  endfunction

  // Outputs depend only on registered state, never on tx_ready.
  assign tx.tx_valid = (state != IDLE);
  assign tx.tx_data  = (state == NL)  ? 8'h0A :
                       (state == HEX) ? hex_char(shreg[31:28]) : 8'h00;

  assign accept   = tx.tx_valid && tx.tx_ready;
  assign last_hex = (state == HEX) && (idx == 3'd7);
  assign eof      = accept && ((last_hex && !SEND_NL) || (state == NL));
  assign busy     = (state != IDLE) || pending_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= 32'h0;
      idx       <= 3'd0;
      pending   <= 32'h0;
      pending_v <= 1'b0;
      drop_cnt  <= 8'h0;
    end else if (state == IDLE) begin
      if (csr_we) begin
        shreg <= csr_wdata;
        idx   <= 3'd0;
        state <= HEX;
      end
    end else if (eof) begin
      // Chain straight into the next frame so back-to-back values have no bubble.
      if (pending_v) begin
        shreg     <= pending;
        idx       <= 3'd0;
        state     <= HEX;
        pending_v <= csr_we;
        if (csr_we)
          pending <= csr_wdata;
      end else if (csr_we) begin
        shreg <= csr_wdata;
        idx   <= 3'd0;
        state <= HEX;
      end else begin
        state <= IDLE;
      end
    end else begin
      if (accept && state == HEX) begin
        shreg <= {shreg[27:0], 4'h0};
        if (idx == 3'd7)
          state <= NL;
        else
          idx <= idx + 3'd1;
      end
      if (csr_we) begin
        pending   <= csr_wdata;
        pending_v <= 1'b1;
        if (pending_v && drop_cnt != 8'hFF)
          drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // Flags latch on the first nonzero write and then ignore everything until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      test_done <= 1'b0;
      test_pass <= 1'b0;
    end else if (csr_we && !test_done && csr_wdata != 32'h0) begin
      test_done <= 1'b1;
      test_pass <= (csr_wdata == 32'h1);
    end
  end

endmodule

// File: tb/tb_tohost_reporter.sv
// tb/tb_tohost_reporter.sv - directed self-checking bench for tohost_reporter
module tb_tohost_reporter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        csr_we = 1'b0;
  logic [31:0] csr_wdata = 32'h0;
  logic        tx_ready = 1'b0;

  logic       busy0, busy1, busy2;
  logic [7:0] drop0, drop1, drop2;
  logic       done0, done1_o, done2;
  logic       pass0, pass1_o, pass2;

  int checks = 0;
  int failures = 0;

  logic [7:0] g0 [0:19];
  logic [7:0] g1 [0:19];
  logic [7:0] g2 [0:19];
  int cnt0, cnt1, cnt2, gaps, first_k, stable_bad;
  logic done_k1, pass_k1;

  tohost_reporter_if if0 ();
  tohost_reporter_if if1 ();
  tohost_reporter_if if2 ();
  assign if0.tx_ready = tx_ready;
  assign if1.tx_ready = tx_ready;
  assign if2.tx_ready = tx_ready;

  tohost_reporter #(.SEND_NL(1'b1), .UPPER(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .csr_we(csr_we), .csr_wdata(csr_wdata), .tx(if0.master),
    .busy(busy0), .drop_cnt(drop0), .test_done(done0), .test_pass(pass0));
  tohost_reporter #(.SEND_NL(1'b1), .UPPER(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .csr_we(csr_we), .csr_wdata(csr_wdata), .tx(if1.master),
    .busy(busy1), .drop_cnt(drop1), .test_done(done1_o), .test_pass(pass1_o));
  tohost_reporter #(.SEND_NL(1'b0), .UPPER(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .csr_we(csr_we), .csr_wdata(csr_wdata), .tx(if2.master),
    .busy(busy2), .drop_cnt(drop2), .test_done(done2), .test_pass(pass2));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    csr_we = 1'b0;
    csr_wdata = 32'h0;
    tx_ready = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Iteration k drives the cycle after edge k-1; writes are issued at chosen k.
  task automatic collect(input int n, input int mode, input int nw,
                         input int wc0, input logic [31:0] wd0,
                         input int wc1, input logic [31:0] wd1,
                         input int wc2, input logic [31:0] wd2);
    logic held0, held1;
    logic [7:0] hd0, hd1;
    cnt0 = 0; cnt1 = 0; cnt2 = 0; gaps = 0; first_k = -1; stable_bad = 0;
    held0 = 1'b0; held1 = 1'b0; hd0 = 8'h0; hd1 = 8'h0;
    done_k1 = 1'b0; pass_k1 = 1'b0;
    for (int k = 0; k < 300 && cnt0 < n; k++) begin
      csr_we = 1'b0;
      csr_wdata = 32'h0;
      if (nw > 0 && k == wc0) begin csr_we = 1'b1; csr_wdata = wd0; end
      if (nw > 1 && k == wc1) begin csr_we = 1'b1; csr_wdata = wd1; end
      if (nw > 2 && k == wc2) begin csr_we = 1'b1; csr_wdata = wd2; end
      if (mode == 0) tx_ready = 1'b1;
      else tx_ready = (k > 0) && (((k - 1) % 4 == 0) || ((k - 1) % 4 == 3));
      if (k == 1) begin done_k1 = done0; pass_k1 = pass0; end
      if (held0 && (!if0.tx_valid || if0.tx_data !== hd0)) stable_bad++;
      if (held1 && (!if1.tx_valid || if1.tx_data !== hd1)) stable_bad++;
      if (if0.tx_valid) begin
        if (first_k < 0) first_k = k;
      end else if (first_k >= 0) begin
        gaps++;
      end
      if (if0.tx_valid && tx_ready && cnt0 < 20) begin g0[cnt0] = if0.tx_data; cnt0++; end
      if (if1.tx_valid && tx_ready && cnt1 < 20) begin g1[cnt1] = if1.tx_data; cnt1++; end
      if (if2.tx_valid && tx_ready && cnt2 < 20) begin g2[cnt2] = if2.tx_data; cnt2++; end
      held0 = if0.tx_valid && !tx_ready; hd0 = if0.tx_data;
      held1 = if1.tx_valid && !tx_ready; hd1 = if1.tx_data;
      step();
    end
    csr_we = 1'b0;
    csr_wdata = 32'h0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({if0.tx_valid, if1.tx_valid, if2.tx_valid, busy0, busy1, busy2} !== 6'b0) begin
      failures++; $display("FAIL reset_valid_busy got=%b exp=000000",
        {if0.tx_valid, if1.tx_valid, if2.tx_valid, busy0, busy1, busy2});
    end
    checks++;
    if ({drop0, done0, pass0, if0.tx_data} !== 18'h0) begin
      failures++; $display("FAIL reset_outputs drop=%h done=%b pass=%b data=%h exp all 0",
        drop0, done0, pass0, if0.tx_data);
    end
  endtask

  task automatic test_pass_value();
    logic [7:0] exp [0:8] = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h0A};
    do_reset();
    collect(9, 0, 1, 0, 32'h00000001, 0, 32'h0, 0, 32'h0);
    checks++;
    if (first_k !== 1) begin failures++; $display("FAIL one_latency got=%0d exp=1", first_k); end
    checks++;
    if (cnt0 !== 9) begin failures++; $display("FAIL one_count got=%0d exp=9", cnt0); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (g0[i] !== exp[i]) begin
        failures++; $display("FAIL one_byte%0d got=%h exp=%h", i, g0[i], exp[i]);
      end
    end
    checks++;
    if (gaps !== 0) begin failures++; $display("FAIL one_gaps got=%0d exp=0", gaps); end
    checks++;
    if ({done_k1, pass_k1} !== 2'b11) begin
      failures++; $display("FAIL one_flags_t1 got=%b exp=11", {done_k1, pass_k1});
    end
    checks++;
    if ({if0.tx_valid, busy0} !== 2'b00) begin
      failures++; $display("FAIL one_idle_after got=%b exp=00", {if0.tx_valid, busy0});
    end
  endtask

  task automatic test_deadbeef_stall();
    logic [7:0] exp_l [0:8] = '{8'h64, 8'h65, 8'h61, 8'h64, 8'h62, 8'h65, 8'h65, 8'h66, 8'h0A};
    logic [7:0] exp_u [0:8] = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0A};
    do_reset();
    collect(9, 1, 1, 0, 32'hDEADBEEF, 0, 32'h0, 0, 32'h0);
    checks++;
    if (cnt0 !== 9 || cnt1 !== 9) begin
      failures++; $display("FAIL dead_count got=%0d/%0d exp=9/9", cnt0, cnt1);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (g0[i] !== exp_l[i]) begin
        failures++; $display("FAIL dead_lower%0d got=%h exp=%h", i, g0[i], exp_l[i]);
      end
      checks++;
      if (g1[i] !== exp_u[i]) begin
        failures++; $display("FAIL dead_upper%0d got=%h exp=%h", i, g1[i], exp_u[i]);
      end
    end
    checks++;
    if (cnt2 !== 8) begin failures++; $display("FAIL nonl_count got=%0d exp=8", cnt2); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (g2[i] !== exp_l[i]) begin
        failures++; $display("FAIL nonl_byte%0d got=%h exp=%h", i, g2[i], exp_l[i]);
      end
    end
    checks++;
    if (if2.tx_valid !== 1'b0) begin failures++; $display("FAIL nonl_idle got=%b exp=0", if2.tx_valid); end
    checks++;
    if (stable_bad !== 0) begin failures++; $display("FAIL dead_stable got=%0d exp=0", stable_bad); end
    checks++;
    if (gaps !== 0) begin failures++; $display("FAIL dead_gaps got=%0d exp=0", gaps); end
    checks++;
    if ({done0, pass0} !== 2'b10) begin
      failures++; $display("FAIL dead_flags got=%b exp=10", {done0, pass0});
    end
  endtask

  task automatic test_flags();
    do_reset();
    tx_ready = 1'b1;
    csr_we = 1'b1; csr_wdata = 32'h0;
    step();
    csr_we = 1'b0;
    checks++;
    if (done0 !== 1'b0) begin failures++; $display("FAIL flag_zero got=%b exp=0", done0); end
    step();
    csr_we = 1'b1; csr_wdata = 32'h5;
    step();
    csr_we = 1'b0;
    checks++;
    if ({done0, pass0} !== 2'b10) begin
      failures++; $display("FAIL flag_five got=%b exp=10", {done0, pass0});
    end
    step();
    csr_we = 1'b1; csr_wdata = 32'h1;
    step();
    csr_we = 1'b0;
    checks++;
    if ({done0, pass0} !== 2'b10) begin
      failures++; $display("FAIL flag_frozen got=%b exp=10", {done0, pass0});
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    collect(18, 0, 3, 0, 32'h11111111, 2, 32'h22222222, 4, 32'h33333333);
    checks++;
    if (cnt0 !== 18) begin failures++; $display("FAIL b2b_count got=%0d exp=18", cnt0); end
    for (int i = 0; i < 18; i++) begin
      logic [7:0] e;
      e = (i == 8 || i == 17) ? 8'h0A : ((i < 8) ? 8'h31 : 8'h33);
      checks++;
      if (g0[i] !== e) begin failures++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, g0[i], e); end
    end
    checks++;
    if (gaps !== 0) begin failures++; $display("FAIL b2b_gaps got=%0d exp=0", gaps); end
    checks++;
    if (drop0 !== 8'd1) begin failures++; $display("FAIL b2b_drop got=%0d exp=1", drop0); end
    checks++;
    if ({if0.tx_valid, busy0} !== 2'b00) begin
      failures++; $display("FAIL b2b_idle got=%b exp=00", {if0.tx_valid, busy0});
    end
  endtask

  task automatic test_eof_write();
    logic [7:0] first [0:8] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h0A};
    do_reset();
    collect(18, 0, 2, 0, 32'h12345678, 9, 32'hAAAAAAAA, 0, 32'h0);
    checks++;
    if (cnt0 !== 18) begin failures++; $display("FAIL eofw_count got=%0d exp=18", cnt0); end
    for (int i = 0; i < 18; i++) begin
      logic [7:0] e;
      e = (i < 9) ? first[i] : ((i == 17) ? 8'h0A : 8'h61);
      checks++;
      if (g0[i] !== e) begin failures++; $display("FAIL eofw_byte%0d got=%h exp=%h", i, g0[i], e); end
    end
    checks++;
    if (gaps !== 0) begin failures++; $display("FAIL eofw_gaps got=%0d exp=0", gaps); end
    checks++;
    if (drop0 !== 8'd0) begin failures++; $display("FAIL eofw_drop got=%0d exp=0", drop0); end
  endtask

  task automatic test_reset_mid_frame();
    int stray;
    do_reset();
    collect(3, 0, 3, 0, 32'h000000FF, 2, 32'h00000002, 3, 32'h00000003);
    checks++;
    if ({busy0, drop0, done0} !== {1'b1, 8'd1, 1'b1}) begin
      failures++; $display("FAIL mid_pre_reset busy=%b drop=%0d done=%b exp busy=1 drop=1 done=1",
        busy0, drop0, done0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({if0.tx_valid, busy0, drop0, done0, pass0} !== 12'h0) begin
      failures++; $display("FAIL mid_async valid=%b busy=%b drop=%0d done=%b pass=%b exp all 0",
        if0.tx_valid, busy0, drop0, done0, pass0);
    end
    step();
    rst_n = 1'b1;
    tx_ready = 1'b1;
    stray = 0;
    for (int k = 0; k < 12; k++) begin
      if (if0.tx_valid || if1.tx_valid || if2.tx_valid) stray++;
      step();
    end
    checks++;
    if (stray !== 0) begin failures++; $display("FAIL mid_no_resume got=%0d exp=0", stray); end
  endtask

  initial begin
    test_reset();
    test_pass_value();
    test_deadbeef_stall();
    test_flags();
    test_back_to_back();
    test_eof_write();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tohost_reporter.md
Name: tohost_reporter

Overview:
- Host-side consumer of the core's tohost CSR (0x51E).
- Each time the core writes the CSR, the block captures the 32-bit value and streams it as 8 ASCII hex characters, plus an optional newline, over a byte valid/ready interface to the UART transmitter.
- It also decodes the riscv-tests tohost convention into sticky done/pass flags for the bench and board LEDs.
- Sits between the core's CSR write path and the UART TX FIFO.

Parameters:
- SEND_NL, 1, when 1 append 8'h0A after the 8th hex char (9-byte frame); when 0, 8-byte frame.
- UPPER, 0, when 1 emit hex digits A-F as 0x41-0x46; when 0, emit a-f as 0x61-0x66.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- csr_we  input  1  single-cycle strobe: core writes CSR 0x51E this cycle.
- csr_wdata  input  32  value written with csr_we.
- tx_data  output  8  ASCII byte to UART TX.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  UART TX accepts byte when tx_valid && tx_ready.
- busy  output  1  frame in progress or pending value held.
- drop_cnt  output  8  count of overwritten pending values, saturating at 255.
- test_done  output  1  sticky: a nonzero value has been written.
- test_pass  output  1  sticky: first nonzero value written was 32'h1.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; pending_v 0; shift register 0.
- States:
  - IDLE: no frame.
  - HEX: emitting nibble index 0..7, MSB nibble first.
  - NL: emitting 8'h0A; entered only when SEND_NL=1.
- Capture from IDLE: csr_we at cycle t loads shift register at edge t; HEX, index 0; tx_valid=1 from cycle t+1. Latency from strobe to first valid byte is 1 cycle.
- Hex encoding: nibble n<10 gives 8'h30+n. n>=10 gives 8'h61+n-10, or 8'h41+n-10 when UPPER=1.
- Handshake:
  - tx_data stays stable and tx_valid stays high until tx_ready is sampled high.
  - Each accept advances the index by one.
  - tx_valid never drops mid-frame.
  - No combinational path from tx_ready to tx_valid or tx_data.
- End of frame is the accept of index 7 (SEND_NL=0) or of NL (SEND_NL=1). On that edge:
  - pending_v=1: load pending into shift register, HEX index 0, pending_v <= csr_we, pending <= csr_wdata if csr_we. Zero bubble; no drop.
  - pending_v=0 and csr_we=1: load csr_wdata directly, HEX index 0. Zero bubble.
  - Otherwise go to IDLE; tx_valid=0 next cycle.
- csr_we while not IDLE and not at end-of-frame accept:
  - pending_v=0: pending <= csr_wdata, pending_v <= 1.
  - pending_v=1: pending overwritten (newest wins), drop_cnt += 1, saturating at 8'hFF.
- busy = (state != IDLE) | pending_v.
- Status flags:
  - Evaluated on the csr_we strobe itself, independent of transmission.
  - If test_done=0 and csr_wdata != 0: test_done <= 1, test_pass <= (csr_wdata == 32'h1).
  - Once test_done=1, both flags freeze until reset.
  - Writes of 0 never set the flags.
- Reset mid-frame: frame aborts immediately; tx_valid=0 asynchronously; pending, counters and flags cleared. No partial frame resumes after reset release.

Test Plan:
- csr_we with 32'h00000001, tx_ready=1 constantly, SEND_NL=1 -> from t+1, 9 consecutive accepted bytes: 30 30 30 30 30 30 30 31 0A; then tx_valid=0; test_done=1, test_pass=1 at t+1; busy=0 after the last byte.
- csr_we with 32'hDEADBEEF, tx_ready toggled 1,0,0,1 repeating -> bytes 64 65 61 64 62 65 65 66 0A. tx_data holds stable while tx_ready=0; test_done=1, test_pass=0. Repeat with UPPER=1 -> 44 45 41 44 42 45 45 46 0A.
- Write 32'h0 first, then 32'h5 -> test_done stays 0 after the first write; then test_done=1, test_pass=0; a later write of 32'h1 leaves test_pass=0.
- Three writes 0x11111111, 0x22222222, 0x33333333 two cycles apart, tx_ready=1 -> frames for 0x11111111 then 0x33333333 only; drop_cnt=1; the second frame starts the cycle after the first frame's NL accept.
- csr_we with 0xAAAAAAAA coincident with the NL accept of a previous frame, pending empty -> next cycle tx_data=8'h61 with no tx_valid gap; drop_cnt unchanged.
- Assert rst_n=0 after 3 bytes of a frame with a pending value held -> tx_valid, busy, drop_cnt, test_done and test_pass all 0 immediately; after release, no bytes are emitted without a new csr_we.
